// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes (also used by the
// control and hazard units) and the sequencing FSM states.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate at a fixed width. Used both to take
// operand magnitudes and to put the sign back on results.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; MTHI/MTLO write directly from here
//   ST_CALC | one shift-add (mult) or restoring (div) step per cycle
//   ST_FIX  | sign correction, HI/LO write, done pulse
//
// Magnitudes are latched at start so a/b may change afterwards. Multiply
// keeps the 2W-bit accumulator {partial product, remaining multiplier bits};
// divide keeps the quotient (shifted-in dividend) in the low half of the same
// accumulator and the partial remainder in rem_q.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]        mag_a_q, mag_a_d;
  logic [W-1:0]        mag_b_q, mag_b_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [W-1:0]        rem_q, rem_d;
  logic                is_div_q, is_div_d;
  logic                sign_lo_q, sign_lo_d;
  logic                sign_rem_q, sign_rem_d;
  logic [W-1:0]        hi_q, hi_d;
  logic [W-1:0]        lo_q, lo_d;
  logic                done_q, done_d;

  logic                signed_op;
  logic                a_neg, b_neg;
  logic [W-1:0]        a_mag, b_mag;
  logic [W:0]          mul_sum;
  logic [W:0]          div_shift;
  logic [W:0]          div_diff;
  logic                div_ge;
  logic [2*W-1:0]      prod_fix;
  logic [W-1:0]        rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[W-1];
  assign b_neg     = signed_op & b[W-1];

  mdu_abs_neg #(.W(W)) u_abs_a (.din(a), .neg(a_neg), .dout(a_mag));
  mdu_abs_neg #(.W(W)) u_abs_b (.din(b), .neg(b_neg), .dout(b_mag));

  // Low half doubles as the quotient for divides; the upper half stays zero
  // there, so negating the full accumulator also negates the quotient.
  mdu_abs_neg #(.W(2*W)) u_fix_lo  (.din(acc_q), .neg(sign_lo_q),  .dout(prod_fix));
  mdu_abs_neg #(.W(W))   u_fix_rem (.din(rem_q), .neg(sign_rem_q), .dout(rem_fix));

  // Remainder stays below the divisor, so bit W of the difference is the borrow.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mag_a_q : {W{1'b0}})};
  assign div_shift = {rem_q, acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_ge    = ~div_diff[W];

  // Next-state, datapath step and HI/LO write selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    is_div_d   = is_div_q;
    sign_lo_d  = sign_lo_q;
    sign_rem_d = sign_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (op <= OP_DIVU) begin
            state_d    = ST_CALC;
            cnt_d      = '0;
            mag_a_d    = a_mag;
            mag_b_d    = b_mag;
            is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
            sign_lo_d  = a_neg ^ b_neg;
            sign_rem_d = a_neg;
            acc_d      = is_div_d ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
            rem_d      = '0;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_d = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end
          if (cnt_q == CNT_W'(W-1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Flush is ignored here: the op has already architecturally issued.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = (mag_b_q == '0) ? '1 : prod_fix[W-1:0];
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[W-1:0];
          hi_d = prod_fix[2*W-1:W];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      is_div_q   <= 1'b0;
      sign_lo_q  <= 1'b0;
      sign_rem_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      is_div_q   <= is_div_d;
      sign_lo_q  <= sign_lo_d;
      sign_rem_q <= sign_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corners plus random ops
// against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          vectors;
  int          errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // MIPS HI/LO semantics from plain integer arithmetic.
  function automatic void model(input logic [2:0] op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i,
                                output logic [31:0] mh, output logic [31:0] ml);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    mh = 32'h0;
    ml = 32'h0;
    case (op_i)
      3'd0: begin
        p  = longint'($signed(a_i)) * longint'($signed(b_i));
        mh = p[63:32];
        ml = p[31:0];
      end
      3'd1: begin
        u  = {32'd0, a_i} * {32'd0, b_i};
        mh = u[63:32];
        ml = u[31:0];
      end
      3'd2: begin
        if (b_i == 32'd0) begin
          ml = 32'hFFFF_FFFF; mh = a_i;
        end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000; mh = 32'h0;
        end else begin
          sa = $signed(a_i);
          sb = $signed(b_i);
          ml = sa / sb;
          mh = sa % sb;
        end
      end
      3'd3: begin
        if (b_i == 32'd0) begin
          ml = 32'hFFFF_FFFF; mh = a_i;
        end else begin
          ml = a_i / b_i;
          mh = a_i % b_i;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue a mult/div op; optionally poke a stray start mid-op or flush in FIX.
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int poke_at, input bit fix_flush);
    logic [31:0] eh, el;
    int edges, busy_cnt;
    model(op_i, a_i, b_i, eh, el);
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 100) begin
      start = (edges == poke_at);
      if (start) op = 3'($urandom_range(0, 3));
      flush = fix_flush && (edges == 32);
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    flush = 1'b0;
    check("latency", 32'(edges), 32'd33);
    check("busy_cycles", 32'(busy_cnt), 32'd33);
    check("hi", hi, eh);
    check("lo", lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk); #1;
    check("done_one_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic move_to(input logic [2:0] op_i, input logic [31:0] val);
    @(negedge clk);
    start = 1'b1; op = op_i; a = val; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    if (op_i == 3'd4) exp_hi = val;
    if (op_i == 3'd5) exp_lo = val;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_done", {31'd0, done}, 32'd0);
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          edges;
    bit          saw_done;
    vectors = 0;
    errors  = 0;
    exp_hi  = 32'h0;
    exp_lo  = 32'h0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0; flush = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(3'd1, 32'd7, 32'd6, -1, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, -1, 1'b0);
    run_op(3'd3, 32'h1234, 32'd0, -1, 1'b0);
    run_op(3'd2, 32'hFFFF_1234, 32'd0, -1, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);

    // Stray start while busy, then flush arriving in the FIX cycle.
    run_op(3'd3, 32'd100, 32'd7, 5, 1'b0);
    run_op(3'd2, 32'd12345, 32'hFFFF_FFF0, -1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, -1, 1'b0);
    end

    move_to(3'd4, 32'h0000_AAAA);
    move_to(3'd5, 32'h0000_5555);

    // Flush a running MULT: back to idle, no done, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    saw_done = 1'b0;
    while (edges < 9) begin
      @(posedge clk); #1;
      edges++;
      if (done) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_hi", hi, 32'h0000_AAAA);
    check("flush_lo", lo, 32'h0000_5555);

    // Flush together with start in IDLE drops the op.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    op = 3'd4; a = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_mthi_hi", hi, exp_hi);

    // Reserved op codes do nothing.
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd1;
    @(posedge clk); #1;
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, exp_hi);
    check("rsvd_lo", lo, exp_lo);

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'hFFFF_0000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("amid_busy", {31'd0, busy}, 32'd0);
    check("amid_done", {31'd0, done}, 32'd0);
    check("amid_hi", hi, 32'h0);
    check("amid_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    run_op(3'd0, 32'd2, 32'd3, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
